sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives the FIFO RAM storage block: write/read pointers in RAM-cell units, full/empty flags, data counts.
- Adds a first-word-fall-through (FWFT) output buffer with a valid/ready handshake that hides the RAM's 1-cycle read latency.
- Supports unequal write/read widths through the same cell-based addressing the storage block uses.
- Sits between the user write/read ports and the RAM instance. Used in single-clock DDR3 command/data buffering paths.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fwft_out_buf.sv | 75 +++++++
 rtl/sync_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO controller.
// Cell-ratio derivation for the default widths plus the output-buffer occupancy encoding.
package fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int FIFO_RAM_WIDTH      = 8;
    localparam int FIFO_WR_WIDTH       = 32;
    localparam int FIFO_RD_WIDTH       = 64;
    localparam int FIFO_RAM_DEPTH      = 64;
    localparam int FIFO_RAM_ADDR_WIDTH = clog2(FIFO_RAM_DEPTH);
    localparam int FIFO_CNT_WIDTH      = FIFO_RAM_ADDR_WIDTH + 1;
    localparam int FIFO_WR_IND         = FIFO_WR_WIDTH / FIFO_RAM_WIDTH;
    localparam int FIFO_RD_IND         = FIFO_RD_WIDTH / FIFO_RAM_WIDTH;
    localparam int FIFO_WR_L2          = clog2(FIFO_WR_IND);
    localparam int FIFO_RD_L2          = clog2(FIFO_RD_IND);

    // Value of the encoding is the number of words held in the output buffer.
    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_ONE   = 2'd1,
        OUT_TWO   = 2'd2
    } fifo_out_state_e;

endpackage

// File: rtl/fwft_out_buf.sv
// Two-entry first-word-fall-through output queue (head + skid) fed by RAM captures.
// Pop is applied first; a capture lands in the first free slot after the pop.
module fwft_out_buf
    import fifo_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap,
    input  logic [W-1:0] cap_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   out_cnt
);

    fifo_out_state_e state, state_nx;
    logic [W-1:0]    skid;
    logic            ld_head_cap, ld_head_skid, ld_skid;

    always_ff @(posedge clk) begin
        if (rst) state <= OUT_EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        ld_head_cap  = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (cap) begin
                    ld_head_cap = 1'b1;
                    state_nx    = OUT_ONE;
                end
            end
            OUT_ONE: begin
                if (pop && cap) begin
                    ld_head_cap = 1'b1;
                end else if (pop) begin
                    state_nx = OUT_EMPTY;
                end else if (cap) begin
                    ld_skid  = 1'b1;
                    state_nx = OUT_TWO;
                end
            end
            OUT_TWO: begin
                // The fetch gate upstream never lets a capture arrive here without a pop.
                if (pop) begin
                    ld_head_skid = 1'b1;
                    if (cap) ld_skid  = 1'b1;
                    else     state_nx = OUT_ONE;
                end
            end
            default: state_nx = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (ld_head_cap)       head <= cap_data;
            else if (ld_head_skid) head <= skid;
            if (ld_skid)           skid <= cap_data;
        end
    end

    assign valid   = (state != OUT_EMPTY);
    assign out_cnt = state;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: cell-addressed pointers into the storage RAM,
// full/count flags, and a FWFT output buffer that hides the RAM's read latency.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int RAM_DEPTH      = FIFO_RAM_DEPTH,
    parameter int RAM_ADDR_WIDTH = FIFO_RAM_ADDR_WIDTH,
    parameter int WR_WIDTH       = FIFO_WR_WIDTH,
    parameter int RD_WIDTH       = FIFO_RD_WIDTH,
    parameter int RAM_WIDTH      = FIFO_RAM_WIDTH,
    parameter int WR_IND         = FIFO_WR_IND,
    parameter int RD_IND         = FIFO_RD_IND,
    parameter int CNT_WIDTH      = FIFO_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_WIDTH-1:0]       wr_data,
    output logic                      full,
    output logic                      wr_err,
    input  logic                      rd_en,
    output logic [RD_WIDTH-1:0]       rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic [CNT_WIDTH-1:0]      rd_data_count,
    output logic                      ram_wr_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [WR_WIDTH-1:0]       ram_wr_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RD_WIDTH-1:0]       ram_rd_data
);

    localparam int WR_L2 = clog2(WR_IND);
    localparam int RD_L2 = clog2(RD_IND);
    localparam logic [CNT_WIDTH-1:0] WR_STEP = CNT_WIDTH'(WR_IND);
    localparam logic [CNT_WIDTH-1:0] RD_STEP = CNT_WIDTH'(RD_IND);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(RAM_DEPTH);

    if ((RAM_DEPTH % WR_IND) != 0 || (RAM_DEPTH % RD_IND) != 0) begin : g_bad_ratio
        $error("sync_fifo_ctrl: RAM_DEPTH must be a multiple of WR_IND and RD_IND");
    end
    if (WR_IND * RAM_WIDTH != WR_WIDTH || RD_IND * RAM_WIDTH != RD_WIDTH) begin : g_bad_width
        $error("sync_fifo_ctrl: port widths must be whole multiples of RAM_WIDTH");
    end
    if ((1 << RAM_ADDR_WIDTH) != RAM_DEPTH || CNT_WIDTH != RAM_ADDR_WIDTH + 1) begin : g_bad_depth
        $error("sync_fifo_ctrl: RAM_DEPTH must be 2**RAM_ADDR_WIDTH, CNT_WIDTH one wider");
    end
    if ((1 << WR_L2) != WR_IND || (1 << RD_L2) != RD_IND) begin : g_bad_pow2
        $error("sync_fifo_ctrl: WR_IND and RD_IND must be powers of two");
    end

    logic [CNT_WIDTH-1:0] wr_ptr, rd_ptr, used, free;
    logic                 pend, pop, fetch, wr_ok;
    logic [1:0]           out_cnt, occ, lim;

    // used counts cells written but not yet fetched; wrap bit makes full/empty unambiguous.
    assign used  = wr_ptr - rd_ptr;
    assign free  = DEPTH_C - used;
    assign full  = (free < WR_STEP);
    assign wr_ok = wr_en & ~full;

    assign ram_wr_en   = wr_ok;
    assign ram_wr_data = wr_data;
    assign ram_wr_addr = wr_ptr[RAM_ADDR_WIDTH-1:0];
    assign ram_rd_addr = rd_ptr[RAM_ADDR_WIDTH-1:0];

    // Only fetch when the word will have a slot once it arrives a cycle later.
    assign pop   = rd_en & rd_valid;
    assign occ   = out_cnt + {1'b0, pend};
    assign lim   = 2'd2 + {1'b0, pop};
    assign fetch = (used >= RD_STEP) & (occ < lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pend   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + WR_STEP;
            if (fetch) rd_ptr <= rd_ptr + RD_STEP;
            pend   <= fetch;
            wr_err <= wr_en & full;
        end
    end

    fwft_out_buf #(.W(RD_WIDTH)) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .cap      (pend),
        .cap_data (ram_rd_data),
        .pop      (pop),
        .head     (rd_data),
        .valid    (rd_valid),
        .out_cnt  (out_cnt)
    );

    assign empty         = ~rd_valid;
    assign rd_data_count = (used >> RD_L2) + CNT_WIDTH'(pend) + CNT_WIDTH'(out_cnt);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized scoreboard bench for sync_fifo_ctrl with a byte-cell RAM model.
module tb_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full, wr_err, rd_valid, empty, ram_wr_en;
    logic [63:0] rd_data;
    logic [63:0] ram_rd_data = '0;
    logic [6:0]  rd_data_count;
    logic [5:0]  ram_wr_addr, ram_rd_addr;
    logic [31:0] ram_wr_data;

    always #5 clk = ~clk;

    sync_fifo_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .rd_data_count(rd_data_count), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Storage block: byte cells, first cell of a word holds its most significant byte.
    logic [7:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_wr_en)
            for (int i = 0; i < 4; i++) mem[6'(ram_wr_addr + i)] <= ram_wr_data[31-8*i -: 8];
        for (int j = 0; j < 8; j++) ram_rd_data[63-8*j -: 8] <= mem[6'(ram_rd_addr + j)];
    end

    int          checks = 0, errors = 0;
    int          written = 0, popped = 0;
    bit          mon_en = 1'b0;
    bit          have_half = 1'b0;
    logic [31:0] half;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each pair of accepted writes forms one read word, earlier write on top.
    task automatic drive(input bit we, input bit re, input logic [31:0] d, input bit acc);
        @(posedge clk); #1;
        wr_en = we; rd_en = re; wr_data = d;
        if (we && acc) begin
            written++;
            if (!have_half) begin half = d; have_half = 1'b1; end
            else begin exp_q.push_back({half, d}); have_half = 1'b0; end
        end
    endtask

    // A write is guaranteed to land when total held cells leave room even if none were fetched.
    function automatic bit can_write();
        return (written * 4 - popped * 8) <= 60;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("empty_vs_valid", empty, !rd_valid);
            if (rd_valid && rd_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pop: got %h expected no data", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
                popped++;
            end
        end
    end

    // After idling, the buffer holds min(2, words) and the RAM keeps the rest.
    task automatic settle(input string tag);
        int cells, words, bufw, used_c;
        repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        cells  = written * 4 - popped * 8;
        words  = cells / 8;
        bufw   = (words > 2) ? 2 : words;
        used_c = cells - 8 * bufw;
        check({tag, "_count"}, rd_data_count, words);
        check({tag, "_empty"}, empty, (words == 0));
        check({tag, "_full"},  full, ((64 - used_c) < 4));
        check({tag, "_waddr"}, ram_wr_addr, (written * 4) % 64);
        check({tag, "_raddr"}, ram_rd_addr, ((popped + bufw) * 8) % 64);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); have_half = 1'b0; written = 0; popped = 0;
        @(negedge clk);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_count", rd_data_count, 7'd0);
        check("rst_rd_data", rd_data, 64'h0);
        check("rst_waddr", ram_wr_addr, 6'd0);
        check("rst_raddr", ram_rd_addr, 6'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard, t;
        bit we;
        do_reset();
        mon_en = 1'b1;

        // First-word latency and word ordering.
        drive(1'b1, 1'b0, 32'h11111111, 1'b1);
        drive(1'b1, 1'b0, 32'h22222222, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check("lat_edge0_valid", rd_valid, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check("lat_edge1_valid", rd_valid, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check("lat_edge2_valid", rd_valid, 1'b1);
        check("lat_data", rd_data, 64'h1111111122222222);
        check("lat_count", rd_data_count, 7'd1);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        settle("lat");

        // Fill to full, then a rejected write.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, $urandom, 1'b1);
        settle("fill16");
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, $urandom, 1'b1);
        settle("fill20");
        drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("rej_ram_wr_en", ram_wr_en, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check("rej_wr_err_pulse", wr_err, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check("rej_wr_err_clear", wr_err, 1'b0);
        settle("rej");

        // Drain at full rate.
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); check("drain_valid", rd_valid, 1'b1);
        end
        @(negedge clk); check("drain_done_valid", rd_valid, 1'b0);
        settle("drain");

        // Streaming writes and reads together.
        for (int i = 0; i < 80; i++) begin
            we = can_write();
            drive(we, 1'b1, $urandom, we);
            @(negedge clk);
            check("stream_wr_err", wr_err, 1'b0);
            check("stream_count_le2", (rd_data_count <= 7'd2), 1'b1);
        end
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
        check("stream_drain_timeout", (t < 200), 1'b1);
        settle("stream");

        // Random fill/drain rounds that wrap the pointers several times.
        for (int r = 0; r < 5; r++) begin
            n = 0; guard = 0;
            while (n < 40 && guard < 2000) begin
                we = ($urandom_range(0, 3) != 0) && can_write();
                drive(we, 1'($urandom_range(0, 1)), $urandom, we);
                if (we) n++;
                guard++;
            end
            check("wrap_write_budget", (n == 40), 1'b1);
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            t = 0;
            while ((exp_q.size() != 0 || have_half) && t < 200) begin @(posedge clk); t++; end
            check("wrap_drain_timeout", (t < 200), 1'b1);
            settle($sformatf("wrap%0d", r));
        end

        // Reset with a fetch in flight and data buffered.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, $urandom, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
        drive(1'b1, 1'b0, 32'h5A5A5A5A, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("post_rst_data", rd_data, 64'hA5A5A5A55A5A5A5A);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        settle("post_rst");
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
